// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the minisys-32 instruction fetch stage:
// FSM encoding, reset PC default and instruction field layout.
package ifetch_unit_pkg;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;
    localparam int TARGET_W   = TARGET_MSB - TARGET_LSB + 1;

    // Byte address <-> word address shift.
    localparam int WORD_SHIFT = 2;

    function automatic logic [OP_MSB-OP_LSB:0] inst_op(input logic [31:0] inst);
        return inst[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [FUNCT_MSB-FUNCT_LSB:0] inst_funct(input logic [31:0] inst);
        return inst[FUNCT_MSB:FUNCT_LSB];
    endfunction

endpackage

// File: rtl/ifetch_unit_npc_calc.sv
// Next-PC resolution for the held instruction, plus the sequential pc+4.
// Priority: Jr, then Jmp/Jal, then a taken branch, then fall-through.
module ifetch_unit_npc_calc
    import ifetch_unit_pkg::*;
(
    input  logic [31:0]         pc,
    input  logic [TARGET_W-1:0] jump_target,
    input  logic                Jr,
    input  logic                Jmp,
    input  logic                Jal,
    input  logic                Branch,
    input  logic                nBranch,
    input  logic                Zero,
    input  logic [31:0]         Imm_ext,
    input  logic [31:0]         Read_data_1,
    output logic [31:0]         pc4,
    output logic [31:0]         next_pc
);

    logic        branch_taken;
    logic [31:0] jr_target;
    logic [31:0] jump_addr;
    logic [31:0] branch_addr;

    assign pc4          = pc + 32'd4;
    assign branch_taken = (Branch & Zero) | (nBranch & ~Zero);
    // A misaligned register target is still forced onto a word boundary.
    assign jr_target    = Read_data_1 & ~32'(3);
    assign jump_addr    = {pc4[31:28], jump_target, {WORD_SHIFT{1'b0}}};
    assign branch_addr  = pc4 + (Imm_ext << WORD_SHIFT);

    always_comb begin
        next_pc = pc4;
        if (Jr) begin
            next_pc = jr_target;
        end else if (Jmp || Jal) begin
            next_pc = jump_addr;
        end else if (branch_taken) begin
            next_pc = branch_addr;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word over a req/ack port,
// holds it until decode accepts it, then steps to the resolved next PC.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          IMEM_ADDR_W = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic                   imem_ack,
    input  logic [31:0]            imem_rdata,
    output logic [31:0]            inst,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    input  logic                   Jr,
    input  logic                   Jmp,
    input  logic                   Jal,
    input  logic                   Branch,
    input  logic                   nBranch,
    input  logic                   Zero,
    input  logic [31:0]            Imm_ext,
    input  logic [31:0]            Read_data_1,
    output logic [31:0]            pc,
    output logic [31:0]            link_addr,
    output logic                   fetch_err,
    output logic [31:0]            retired_cnt
);

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] pc_reg;
    logic [31:0] inst_reg;
    logic        inst_valid_reg;
    logic        fetch_err_reg;
    logic [31:0] retired_cnt_reg;
    logic [31:0] next_pc;
    logic [31:0] pc4;
    logic        accept;
    logic        fill;

    ifetch_unit_npc_calc u_npc_calc (
        .pc          (pc_reg),
        .jump_target (inst_reg[TARGET_MSB:TARGET_LSB]),
        .Jr          (Jr),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Zero        (Zero),
        .Imm_ext     (Imm_ext),
        .Read_data_1 (Read_data_1),
        .pc4         (pc4),
        .next_pc     (next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH: if (imem_ack)   state_next = S_HOLD;
            S_HOLD:  if (inst_ready) state_next = S_FETCH;
            default: state_next = S_FETCH;
        endcase
    end

    // The request drops in the reset cycle itself so an in-flight fetch is abandoned.
    always_comb begin
        imem_req = 1'b0;
        if (state_reg == S_FETCH && !rst) begin
            imem_req = 1'b1;
        end
    end

    assign fill   = (state_reg == S_FETCH) && imem_ack;
    assign accept = (state_reg == S_HOLD) && inst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            inst_reg        <= 32'd0;
            inst_valid_reg  <= 1'b0;
            fetch_err_reg   <= 1'b0;
            retired_cnt_reg <= 32'd0;
        end else begin
            if (fill) begin
                inst_reg       <= imem_rdata;
                inst_valid_reg <= 1'b1;
            end
            if (accept) begin
                pc_reg          <= next_pc;
                inst_valid_reg  <= 1'b0;
                retired_cnt_reg <= retired_cnt_reg + 32'd1;
                if (Jr && (Read_data_1[1:0] != 2'b00)) begin
                    fetch_err_reg <= 1'b1;
                end
            end
        end
    end

    assign imem_addr   = pc_reg[IMEM_ADDR_W+WORD_SHIFT-1:WORD_SHIFT];
    assign inst        = inst_reg;
    assign inst_valid  = inst_valid_reg;
    assign pc          = pc_reg;
    assign link_addr   = pc4;
    assign fetch_err   = fetch_err_reg;
    assign retired_cnt = retired_cnt_reg;

endmodule
